ime_mb_sched: RTL
=================

IME_MB_SCHED -- requirements
Module: ime_mb_sched

Interface
REQ-001 SHALL have parameter PIC_W_MB_LEN, default 8, width of MB x index.
REQ-002 SHALL have parameter PIC_H_MB_LEN, default 8, width of MB y index.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  picture start pulse.
- total_x_i  in  PIC_W_MB_LEN  last MB column index (width in MBs minus 1).
- total_y_i  in  PIC_H_MB_LEN  last MB row index.
- ime_done_i  in  1  IME finished current MB (pulse).
- fme_done_i  in  1  FME finished current MB (pulse).
- busy_o  out  1  picture in progress.
- ime_start_o  out  1  IME start pulse.
- ime_mb_x_o  out  PIC_W_MB_LEN  MB x for IME.
- ime_mb_y_o  out  PIC_H_MB_LEN  MB y for IME.
- fme_start_o  out  1  FME start pulse.
- fme_mb_x_o  out  PIC_W_MB_LEN  MB x for FME.
- fme_mb_y_o  out  PIC_H_MB_LEN  MB y for FME.
- pic_done_o  out  1  picture complete pulse.

Function
REQ-005 SHALL run a two-stage lockstep MB pipeline: in slot k, IME processes MB k and FME processes MB k-1, raster order; N MBs take N+1 slots.
REQ-006 SHALL implement states IDLE, LAUNCH, WAIT, DONE.
REQ-007 IDLE: on start_i=1, SHALL latch total_x_i/total_y_i, zero IME coordinates, set slot to 0, and enter LAUNCH next cycle; busy_o=1 from that cycle until return to IDLE.
REQ-008 LAUNCH (exactly 1 cycle): SHALL assert ime_start_o if IME stage is active (slot<N), and fme_start_o if FME stage is active (slot>=1); SHALL clear both sticky done flags; SHALL go to WAIT.
REQ-009 WAIT: SHALL set a sticky flag per stage on ime_done_i/fme_done_i; SHALL treat an inactive stage as already done.
REQ-010 WAIT exit: the cycle in which all active stages are done (including done arriving that cycle), SHALL advance the slot and go to LAUNCH, or to DONE if the completed slot was slot N; next start pulse appears the cycle after the last done.
REQ-011 Advance: fme_mb_x/y_o SHALL take the old ime_mb_x/y_o; IME x SHALL increment, wrapping to 0 after total_x with y incremented; x/y SHALL stay unchanged once the last MB (total_x,total_y) has been issued.
REQ-012 DONE: SHALL pulse pic_done_o for 1 cycle and return to IDLE; busy_o=0 in that IDLE cycle.
REQ-013 Coordinate outputs SHALL be registered, stable from LAUNCH until the next advance, and SHALL hold their last values in IDLE.
REQ-014 start_i outside IDLE SHALL be ignored; ime_done_i/fme_done_i outside WAIT, or for an inactive stage, SHALL be ignored.
REQ-015 ime_done_i and fme_done_i arriving in the same cycle SHALL both be accepted; arrival order SHALL not matter.
REQ-016 Slot counter SHALL be wide enough for (2^PIC_W_MB_LEN)*(2^PIC_H_MB_LEN)+1 slots without overflow.

Reset
REQ-017 While rst=1, state SHALL be IDLE; all outputs, coordinates, flags and the slot counter SHALL be 0.
REQ-018 Reset asserted mid-picture SHALL abort the picture immediately, with no pic_done_o and no further start pulses; after reset release, only a new start_i SHALL start a picture.

Verification
REQ-019 total_x=1, total_y=1, start_i, prompt dones -> IME starts at (0,0),(1,0),(0,1),(1,1); FME starts at (0,0),(1,0),(0,1),(1,1) one slot later; 5 LAUNCH cycles; one pic_done_o.
REQ-020 total_x=0, total_y=0 -> slot0: ime_start_o only; slot1: fme_start_o only at (0,0); then pic_done_o.
REQ-021 fme_done_i 10 cycles before ime_done_i in a slot -> next LAUNCH exactly 1 cycle after ime_done_i; swapping the order gives the same result.
REQ-022 ime_done_i and fme_done_i in the same cycle -> next start pulses on the following cycle.
REQ-023 start_i pulsed during WAIT, plus spurious done in IDLE -> no effect on counters, outputs or pic_done_o count.
REQ-024 rst asserted during WAIT of slot 2 -> all outputs 0 at once; no pic_done_o; a new start_i restarts at (0,0).

Source files
------------

// File: rtl/ime_mb_sched.sv
`default_nettype none
// ============================================================================
// Module      : ime_mb_sched
// Description : Two-stage lockstep macroblock scheduler. In slot k, IME works
//               on MB k and FME works on MB k-1, in raster order. A picture of
//               N MBs takes N+1 slots.
// Revision    : 1.0 - initial release
// ============================================================================
module ime_mb_sched #(
  parameter int PIC_W_MB_LEN = 8,
  parameter int PIC_H_MB_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [PIC_W_MB_LEN-1:0] total_x_i,
  input  logic [PIC_H_MB_LEN-1:0] total_y_i,
  input  logic                    ime_done_i,
  input  logic                    fme_done_i,
  output logic                    busy_o,
  output logic                    ime_start_o,
  output logic [PIC_W_MB_LEN-1:0] ime_mb_x_o,
  output logic [PIC_H_MB_LEN-1:0] ime_mb_y_o,
  output logic                    fme_start_o,
  output logic [PIC_W_MB_LEN-1:0] fme_mb_x_o,
  output logic [PIC_H_MB_LEN-1:0] fme_mb_y_o,
  output logic                    pic_done_o
);

  // One extra bit beyond the MB index width so the slot count N+1 never wraps
  // even for the largest picture.
  localparam int SLOT_W = PIC_W_MB_LEN + PIC_H_MB_LEN + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PIC_W_MB_LEN-1:0] r_tot_x;
  logic [PIC_H_MB_LEN-1:0] r_tot_y;
  logic [PIC_W_MB_LEN-1:0] r_ime_x;
  logic [PIC_H_MB_LEN-1:0] r_ime_y;
  logic [PIC_W_MB_LEN-1:0] r_fme_x;
  logic [PIC_H_MB_LEN-1:0] r_fme_y;
  logic [SLOT_W-1:0]       r_slot;
  logic                    r_ime_done;
  logic                    r_fme_done;

  logic [SLOT_W-1:0] w_cols;
  logic [SLOT_W-1:0] w_rows;
  logic [SLOT_W-1:0] w_num_mb;
  logic              w_ime_act;
  logic              w_fme_act;
  logic              w_ime_ok;
  logic              w_fme_ok;
  logic              w_all_done;
  logic              w_last_mb;

  // Picture size in MBs; the product always fits in SLOT_W bits.
  assign w_cols   = SLOT_W'(r_tot_x) + SLOT_W'(1);
  assign w_rows   = SLOT_W'(r_tot_y) + SLOT_W'(1);
  assign w_num_mb = w_cols * w_rows;

  // IME is busy for slots 0..N-1, FME for slots 1..N.
  assign w_ime_act = (r_slot < w_num_mb);
  assign w_fme_act = (r_slot != '0);

  // An idle stage counts as finished; a done arriving this cycle counts too.
  assign w_ime_ok   = !w_ime_act || r_ime_done || ime_done_i;
  assign w_fme_ok   = !w_fme_act || r_fme_done || fme_done_i;
  assign w_all_done = w_ime_ok && w_fme_ok;

  assign w_last_mb = (r_ime_x == r_tot_x) && (r_ime_y == r_tot_y);

  assign ime_mb_x_o = r_ime_x;
  assign ime_mb_y_o = r_ime_y;
  assign fme_mb_x_o = r_fme_x;
  assign fme_mb_y_o = r_fme_y;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    ime_start_o = 1'b0;
    fme_start_o = 1'b0;
    pic_done_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        busy_o      = 1'b1;
        ime_start_o = w_ime_act;
        fme_start_o = w_fme_act;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        busy_o = 1'b1;
        if (w_all_done) begin
          w_state_nxt = (r_slot == w_num_mb) ? DONE : LAUNCH;
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        pic_done_o  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Picture size latch, slot counter, sticky done flags and MB coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tot_x    <= '0;
      r_tot_y    <= '0;
      r_ime_x    <= '0;
      r_ime_y    <= '0;
      r_fme_x    <= '0;
      r_fme_y    <= '0;
      r_slot     <= '0;
      r_ime_done <= 1'b0;
      r_fme_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_tot_x <= total_x_i;
            r_tot_y <= total_y_i;
            r_ime_x <= '0;
            r_ime_y <= '0;
            r_slot  <= '0;
          end
        end
        LAUNCH: begin
          r_ime_done <= 1'b0;
          r_fme_done <= 1'b0;
        end
        WAIT: begin
          if (ime_done_i && w_ime_act) begin
            r_ime_done <= 1'b1;
          end
          if (fme_done_i && w_fme_act) begin
            r_fme_done <= 1'b1;
          end
          if (w_all_done) begin
            r_slot  <= r_slot + SLOT_W'(1);
            r_fme_x <= r_ime_x;
            r_fme_y <= r_ime_y;
            // IME coordinates freeze on the last MB so FME can pick it up.
            if (!w_last_mb) begin
              if (r_ime_x == r_tot_x) begin
                r_ime_x <= '0;
                r_ime_y <= r_ime_y + PIC_H_MB_LEN'(1);
              end else begin
                r_ime_x <= r_ime_x + PIC_W_MB_LEN'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
